// File: rtl/cordic_share_sched.sv
// rtl/cordic_share_sched.sv - shares one pipelined CORDIC across the s/a0/a1 angles of each job
// Optional CORDIC_TIMEOUT_EN adds a WAIT-state watchdog that drives the sticky err_o.
module cordic_share_sched #(
  parameter int DATA_W        = 32,
  parameter int CORDIC_LAT    = 16,
  parameter int JOBS_PER_SLOT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] theta_s,
  input  logic [DATA_W-1:0] theta_a0,
  input  logic [DATA_W-1:0] theta_a1,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] cor_theta_o,
  output logic              cor_vld_o,
  input  logic              cor_vld_i,
  input  logic [DATA_W-1:0] cor_i_i,
  input  logic [DATA_W-1:0] cor_r_i,
  output logic [DATA_W-1:0] s_ival,
  output logic [DATA_W-1:0] s_rval,
  output logic [DATA_W-1:0] a0_ival,
  output logic [DATA_W-1:0] a0_rval,
  output logic [DATA_W-1:0] a1_ival,
  output logic [DATA_W-1:0] a1_rval,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              slot_last_o,
  output logic              err_o
);

  localparam int CNT_W = (JOBS_PER_SLOT > 1) ? $clog2(JOBS_PER_SLOT) : 1;
  localparam logic [CNT_W-1:0] LAST_JOB = CNT_W'(JOBS_PER_SLOT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [1:0]        iss_tag, ret_tag;
  logic [DATA_W-1:0] a0_lat, a1_lat;
  logic [CNT_W-1:0]  job_cnt;
  logic              accept, capture, last_cap, out_fire, timeout;
  logic              in_rdy_d, out_vld_d, slot_last_d, cor_vld_d;
  logic [DATA_W-1:0] cor_theta_d;

  assign accept   = (state == IDLE) && in_vld && in_rdy;
  // Results may start returning while still issuing when the core is short.
  assign capture  = cor_vld_i && ((state == ISSUE) || (state == WAIT));
  assign last_cap = capture && (ret_tag == 2'd2);
  assign out_fire = (state == HOLD) && out_vld && out_rdy;

`ifdef CORDIC_TIMEOUT_EN
  logic [7:0] wdog;
  logic       err;

  assign timeout = (state == WAIT) && !last_cap && (wdog == 8'(CORDIC_LAT + 8));
  assign err_o   = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      wdog <= (state == WAIT) ? wdog + 8'd1 : 8'd0;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: if (iss_tag == 2'd2) state_nxt = WAIT;
      WAIT: begin
        if (last_cap)     state_nxt = HOLD;
        else if (timeout) state_nxt = IDLE;
      end
      HOLD:  if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_rdy_d    = (state_nxt == IDLE);
    out_vld_d   = (state_nxt == HOLD);
    slot_last_d = (state_nxt == HOLD) && (job_cnt == LAST_JOB);
    cor_vld_d   = 1'b0;
    cor_theta_d = cor_theta_o;
    if (accept) begin
      cor_vld_d   = 1'b1;
      cor_theta_d = theta_s;
    end else if ((state == ISSUE) && (iss_tag != 2'd2)) begin
      cor_vld_d   = 1'b1;
      cor_theta_d = (iss_tag == 2'd0) ? a0_lat : a1_lat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_rdy      <= 1'b0;
      out_vld     <= 1'b0;
      slot_last_o <= 1'b0;
      cor_vld_o   <= 1'b0;
      cor_theta_o <= '0;
      iss_tag     <= '0;
      ret_tag     <= '0;
      a0_lat      <= '0;
      a1_lat      <= '0;
      job_cnt     <= '0;
      s_ival      <= '0;
      s_rval      <= '0;
      a0_ival     <= '0;
      a0_rval     <= '0;
      a1_ival     <= '0;
      a1_rval     <= '0;
    end else begin
      in_rdy      <= in_rdy_d;
      out_vld     <= out_vld_d;
      slot_last_o <= slot_last_d;
      cor_vld_o   <= cor_vld_d;
      cor_theta_o <= cor_theta_d;
      if (accept) begin
        a0_lat  <= theta_a0;
        a1_lat  <= theta_a1;
        iss_tag <= '0;
        ret_tag <= '0;
      end else begin
        if (state == ISSUE) iss_tag <= iss_tag + 2'd1;
        if (capture)        ret_tag <= ret_tag + 2'd1;
      end
      if (capture) begin
        case (ret_tag)
          2'd0: begin s_ival  <= cor_i_i; s_rval  <= cor_r_i; end
          2'd1: begin a0_ival <= cor_i_i; a0_rval <= cor_r_i; end
          2'd2: begin a1_ival <= cor_i_i; a1_rval <= cor_r_i; end
          default: ;
        endcase
      end
      if (out_fire) job_cnt <= (job_cnt == LAST_JOB) ? '0 : job_cnt + 1'b1;
    end
  end

endmodule
